// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M iterative divider: widths, op encodings,
// FSM states and the architectural constants for the special cases.
package rv32m_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  localparam logic [XLEN-1:0] DIV0_QUOT = '1;
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  // Two's complement negation, wrapping within XLEN bits.
  function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] v);
    return (~v) + XLEN'(1);
  endfunction

endpackage

// File: rtl/rv32m_divider_div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
module div_step
  import rv32m_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  // The shifted remainder needs XLEN+1 bits: it can reach 2*divisor-1, but
  // after a successful subtract it is below the divisor and fits XLEN again.
  logic [XLEN:0] rem_sh;
  logic          fits;

  always_comb begin
    rem_sh = {rem_i, quo_i[XLEN-1]};
    fits   = (rem_sh >= {1'b0, divisor_i});
    rem_o  = fits ? (rem_sh[XLEN-1:0] - divisor_i) : rem_sh[XLEN-1:0];
    quo_o  = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/rv32m_divider.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) with start/busy/done handshake:
// one shift-subtract step per cycle on magnitudes, then a sign fix-up.
module rv32m_divider
  import rv32m_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            state_q,   state_d;
  op_e               op_q,      op_d;
  logic              signed_q,  signed_d;
  logic              sa_q,      sa_d;
  logic              sb_q,      sb_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [XLEN-1:0]   quo_q,     quo_d;
  logic [XLEN-1:0]   rem_q,     rem_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [XLEN-1:0]   result_q,  result_d;

  logic [XLEN-1:0]   step_rem, step_quo;
  logic              accept, is_signed, div0, ovf;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign is_signed = ~op[0];
  assign div0      = (b == '0);
  assign ovf       = is_signed && (a == INT_MIN) && (b == '1);
  assign accept    = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !kill;

  assign quo_fix = (signed_q && (sa_q != sb_q)) ? neg2(quo_q) : quo_q;
  assign rem_fix = (signed_q && sa_q)           ? neg2(rem_q) : rem_q;

  // NOTE: every _d gets its hold value first, so no path through the case
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    signed_d  = signed_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d      = op_e'(op);
          signed_d  = is_signed;
          sa_d      = is_signed && a[XLEN-1];
          sb_d      = is_signed && b[XLEN-1];
          quo_d     = (is_signed && a[XLEN-1]) ? neg2(a) : a;
          divisor_d = (is_signed && b[XLEN-1]) ? neg2(b) : b;
          rem_d     = '0;
          cnt_d     = CNT_W'(XLEN - 1);
          // Special cases bypass the iteration and finish one cycle later.
          if (div0) begin
            result_d = op[1] ? a : DIV0_QUOT;
            state_d  = S_DONE;
          end else if (ovf) begin
            result_d = op[1] ? '0 : INT_MIN;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          result_d = ((op_q == OP_REM) || (op_q == OP_REMU)) ? rem_fix : quo_fix;
          state_d  = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, so nothing observable or
  // internal carries state across a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_DIV;
      signed_q  <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      signed_q  <= signed_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_rv32m_divider.sv
// Directed self-checking bench for rv32m_divider: arithmetic, special cases,
// latency, kill, back-to-back starts and asynchronous reset.
module tb_rv32m_divider;
  import rv32m_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            kill;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int errors = 0;
  int checks = 0;
  int lat;
  int busy_cnt;
  int seen_done;

  rv32m_divider dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request at the falling edge; it is taken at the next rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit hold);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Counts falling edges after the accept edge until done; 999 means timeout.
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        return;
      end
      if (busy) nbusy++;
    end
    n = 999;
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    issue(o, x, y, 1'b0);
    wait_done(lat, busy_cnt);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp);
    @(negedge clk);
    check({tag, " done pulse ends"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; a = '0; b = '0;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic unsigned, including busy occupancy
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    wait_done(lat, busy_cnt);
    check("divu 100/7 latency", lat, 34);
    check("divu 100/7 busy cycles", busy_cnt, 33);
    check("divu 100/7 busy low at done", {31'd0, busy}, 32'd0);
    check("divu 100/7 result", result, 32'd14);
    run("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);

    // Signed
    run("div -7/2",  OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run("rem -7/2",  OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run("rem 7/-2",  OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    run("div 7/-2",  OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);

    // Divide by zero and signed overflow
    run("divu x/0",  OP_DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem -5/0",  OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
    run("div ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run("divu ovf operands", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

    // Kill during CALC leaves the prior result in place
    run("divu 50/7", OP_DIVU, 32'd50, 32'd7, 32'd7, 34);
    issue(OP_DIVU, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check("kill busy drops", {31'd0, busy}, 32'd0);
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("kill no done", seen_done, 0);
    check("kill result kept", result, 32'd7);
    run("divu 9/3 after kill", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

    // Kill in DONE: done still pulses, and the concurrent start is refused
    issue(OP_DIVU, 32'd5, 32'd0, 1'b1);
    kill = 1'b1;
    @(negedge clk);
    check("kill in done pulses", {31'd0, done}, 32'd1);
    check("kill in done result", result, 32'hFFFF_FFFF);
    @(negedge clk);
    check("kill blocks start", {31'd0, busy | done}, 32'd0);
    start = 1'b0; kill = 1'b0;

    // Start held high: second op accepted in DONE without an idle bubble
    issue(OP_DIVU, 32'd20, 32'd6, 1'b1);
    wait_done(lat, busy_cnt);
    check("b2b first latency", lat, 34);
    check("b2b first result", result, 32'd3);
    op = OP_REMU;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b no idle bubble", {31'd0, busy}, 32'd1);
    wait_done(lat, busy_cnt);
    check("b2b second latency", lat, 33);
    check("b2b second result", result, 32'd2);

    // Start pulses during CALC are ignored
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (4) @(negedge clk);
    op = OP_DIV; a = 32'd6; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_cnt);
    check("ignored start latency", lat, 14);
    check("ignored start result", result, 32'd14);

    // Asynchronous reset in the middle of an operation
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset done", {31'd0, done}, 32'd0);
    check("async reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("divu 9/3 after reset", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
